status_rf_arbiter: RTL and testbench
====================================

# status_rf_arbiter

Shares the single-ported status register file between N_REQ requesters, for example the fill engine and the lookup pipeline. The block arbitrates between requesters and registers the winning request into an issue stage that drives the register file. It stamps the winner's index onto the register-file tag. It routes each read result back to the requester that issued it, and suppresses the stale or held outputs the register file presents while idle or halted.

## Interface
Parameters:
- WORD_WIDTH, 12, data word width
- ADDR_WIDTH, 3, register-file address width
- N_REQ, 2, number of requesters (2..8)
- ID_WIDTH, 1, clog2(N_REQ); register-file TAG_WIDTH equals ID_WIDTH

Ports:
- clk  in  1  clock
- arst_n  in  1  asynchronous active-low reset
- i_halt  in  1  global stall
- i_req_valid  in  N_REQ  per-requester request valid
- i_req_wen  in  N_REQ  1 = write, 0 = read
- i_req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester k occupies slice k
- i_req_data  in  N_REQ*WORD_WIDTH  packed write data
- o_req_ready  out  N_REQ  request accepted this cycle when valid & ready
- o_rsp_valid  out  N_REQ  one-cycle read-response strobe
- o_rsp_data  out  WORD_WIDTH  read data, shared by all requesters
- o_rsp_init  out  1  read word was initialized
- o_err  out  1  sticky flag: response tag did not match the pending id
- o_rf_valid, o_rf_wen  out  1 each  register-file request
- o_rf_addr  out  ADDR_WIDTH  register-file address
- o_rf_data  out  WORD_WIDTH  register-file write data
- o_rf_tag  out  ID_WIDTH  register-file tag
- o_rf_halt  out  1  register-file halt, driven equal to i_halt
- i_rf_valid, i_rf_data_init  in  1 each  register-file outputs
- i_rf_data  in  WORD_WIDTH  register-file read data
- i_rf_tag  in  ID_WIDTH  register-file returned tag

## Operation
- Protocol: a requester holds valid and its fields stable until ready. At most one bit of o_req_ready is high in any cycle.
- Issue register (valid, wen, addr, data, id) drives the o_rf_* outputs. It is consumed on any cycle with issue valid and i_halt = 0.
- Acceptance: the issue register must be empty or being consumed, i_halt = 0, and the arbiter grants.
  - Grant = round-robin (see Configuration) over i_req_valid.
  - On acceptance: o_req_ready[g] = 1, and the issue register loads requester g's fields with id = g.
- Consuming without a new acceptance clears the issue valid bit.
- rd_pending/rd_id: set on consumption of a read, with rd_id = the issue id. Cleared the following cycle.
- Response:
  - o_rsp_valid[rd_id] = rd_pending & i_rf_valid.
  - o_rsp_data and o_rsp_init pass through combinationally.
  - Responses are not gated by i_halt, because register-file outputs are frozen while halted.
- Stale output filtering: the register file keeps its output when idle or halted. A response is forwarded only when rd_pending = 1.
- Error: if rd_pending = 1 and (i_rf_valid = 0 or i_rf_tag != rd_id), o_err sets and stays set until reset.
- Writes produce no response.

## Timing
- Reset values: issue register empty, rd_pending = 0, round-robin pointer = N_REQ-1 (requester 0 has priority first), o_err = 0. Consequently o_req_ready = 0, o_rsp_valid = 0, and o_rf_valid = 0. o_rsp_data and o_rsp_init follow the register file (0 after reset).
- Read latency: accepted in cycle N, o_rf_valid in cycle N+1, o_rsp_valid in cycle N+2 (no halt). Each halted cycle adds one cycle.
- Throughput: one request per cycle, sustained back-to-back.
- Halt: o_req_ready = 0 and the issue register holds. A response already pending is still delivered in its cycle.
- Simultaneous requests: exactly one is granted per cycle. The others wait with valid held.
- Reset mid-operation: the in-flight issue and pending response are dropped, and no o_rsp_valid is produced.

## Configuration
- STATUS_RF_ARB_RR_EN defined: round-robin. The pointer moves to the granted index on acceptance only, and search starts at pointer+1 with wrap-around.
- STATUS_RF_ARB_RR_EN undefined: fixed priority, lowest index wins, and no pointer register is built.

## Structure
- Shared package/header status_rf_pkg: ID_WIDTH derivation (clog2 function) and the packed-slice width constants.
- Sub-module rr_arbiter (N, with macro-controlled fixed-priority fallback): inputs are the request vector and an advance enable; output is a one-hot grant plus its index.

## Test plan
- Single read: reset, write req0 addr 3 data 0xABC, then read req1 addr 3 -> o_rsp_valid = 2'b10 exactly two cycles after acceptance, data 0xABC, init 1.
- Uninitialized read: read addr 5 after reset -> data 0x000, init 0, one strobe only.
- Contention: req0 and req1 both read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 with the macro defined; all to 0 with it undefined.
- Halt: assert i_halt for 3 cycles while the issue register holds a read -> no ready, o_rf fields stable, response arrives 3 cycles late, single strobe.
- Idle after read: no requests for 5 cycles after a response -> o_rsp_valid stays 0 even though the register file holds its output valid.
- Reset mid-flight: drop arst_n in the cycle after acceptance -> no response strobe, all outputs at reset values, o_err = 0.

Source files
------------

// File: rtl/status_rf_pkg.sv
// status_rf_pkg: shared default widths and the id-width helper for status_rf_arbiter.
package status_rf_pkg;
    localparam int WORD_W = 12;
    localparam int ADDR_W = 3;
    localparam int NREQ   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/status_rf_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot request arbiter with grant index.
// STATUS_RF_ARB_RR_EN selects round-robin; otherwise fixed lowest-index priority with no pointer.
module rr_arbiter
    import status_rf_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_adv,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
`ifdef STATUS_RF_ARB_RR_EN
    logic [IW-1:0] r_ptr;
    int            w_k;

    // Scan from the farthest offset down so the nearest requester after r_ptr wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_k   = 0;
        for (int i = N; i >= 1; i--) begin
            w_k = int'(r_ptr) + i;
            w_k = (w_k >= N) ? w_k - N : w_k;
            if (i_req[IW'(w_k)]) begin
                o_gnt = '0;
                o_gnt[IW'(w_k)] = 1'b1;
                o_idx = IW'(w_k);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_ptr <= IW'(N - 1);
        else if (i_adv) r_ptr <= o_idx;
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, arst_n, i_adv};

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt = '0;
                o_gnt[i] = 1'b1;
                o_idx = IW'(i);
            end
        end
    end
`endif
endmodule

// File: rtl/status_rf_arbiter.sv
// status_rf_arbiter: shares a single-ported status register file between N_REQ requesters.
// Arbitration mode is selected by STATUS_RF_ARB_RR_EN (round-robin) or fixed priority when undefined.
module status_rf_arbiter
    import status_rf_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int N_REQ      = NREQ,
    parameter int ID_WIDTH   = clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic                        i_halt,
    input  logic [N_REQ-1:0]            i_req_valid,
    input  logic [N_REQ-1:0]            i_req_wen,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [N_REQ*WORD_WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]            o_req_ready,
    output logic [N_REQ-1:0]            o_rsp_valid,
    output logic [WORD_WIDTH-1:0]       o_rsp_data,
    output logic                        o_rsp_init,
    output logic                        o_err,
    output logic                        o_rf_valid,
    output logic                        o_rf_wen,
    output logic [ADDR_WIDTH-1:0]       o_rf_addr,
    output logic [WORD_WIDTH-1:0]       o_rf_data,
    output logic [ID_WIDTH-1:0]         o_rf_tag,
    output logic                        o_rf_halt,
    input  logic                        i_rf_valid,
    input  logic                        i_rf_data_init,
    input  logic [WORD_WIDTH-1:0]       i_rf_data,
    input  logic [ID_WIDTH-1:0]         i_rf_tag
);
    logic [N_REQ-1:0]      w_gnt;
    logic [ID_WIDTH-1:0]   w_gidx;
    logic                  w_accept;
    logic                  w_consume;
    logic [ADDR_WIDTH-1:0] w_addr [N_REQ];
    logic [WORD_WIDTH-1:0] w_data [N_REQ];

    logic                  r_iss_valid;
    logic                  r_iss_wen;
    logic [ADDR_WIDTH-1:0] r_iss_addr;
    logic [WORD_WIDTH-1:0] r_iss_data;
    logic [ID_WIDTH-1:0]   r_iss_id;
    logic                  r_rd_pending;
    logic [ID_WIDTH-1:0]   r_rd_id;
    logic                  r_err;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g] = i_req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data[g] = i_req_data[g*WORD_WIDTH +: WORD_WIDTH];
    end

    rr_arbiter #(.N(N_REQ), .IW(ID_WIDTH)) u_arb (
        .clk    (clk),
        .arst_n (arst_n),
        .i_req  (i_req_valid),
        .i_adv  (w_accept),
        .o_gnt  (w_gnt),
        .o_idx  (w_gidx)
    );

    // With halt low the issue register is always either empty or draining, so only halt blocks acceptance.
    assign w_accept    = !i_halt && (|w_gnt);
    assign w_consume   = r_iss_valid && !i_halt;
    assign o_req_ready = w_accept ? w_gnt : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_iss_valid  <= 1'b0;
            r_iss_wen    <= 1'b0;
            r_iss_addr   <= '0;
            r_iss_data   <= '0;
            r_iss_id     <= '0;
            r_rd_pending <= 1'b0;
            r_rd_id      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iss_valid <= 1'b1;
                r_iss_wen   <= i_req_wen[w_gidx];
                r_iss_addr  <= w_addr[w_gidx];
                r_iss_data  <= w_data[w_gidx];
                r_iss_id    <= w_gidx;
            end else if (w_consume) begin
                r_iss_valid <= 1'b0;
            end
            r_rd_pending <= w_consume && !r_iss_wen;
            if (w_consume) r_rd_id <= r_iss_id;
            r_err <= r_err || (r_rd_pending && (!i_rf_valid || (i_rf_tag != r_rd_id)));
        end
    end

    // The register file holds its outputs while idle; only a pending read may raise a strobe.
    always_comb begin
        o_rsp_valid = '0;
        if (r_rd_pending && i_rf_valid) o_rsp_valid[r_rd_id] = 1'b1;
    end

    assign o_rsp_data = i_rf_data;
    assign o_rsp_init = i_rf_data_init;
    assign o_err      = r_err;
    assign o_rf_valid = r_iss_valid;
    assign o_rf_wen   = r_iss_wen;
    assign o_rf_addr  = r_iss_addr;
    assign o_rf_data  = r_iss_data;
    assign o_rf_tag   = r_iss_id;
    assign o_rf_halt  = i_halt;
endmodule

// File: tb/tb_status_rf_arbiter.sv
// tb_status_rf_arbiter: directed stimulus, a register-file stand-in, and a transaction-level
// model that is compared against the DUT on every negative clock edge.
module tb_status_rf_arbiter;
    localparam int WW = 12;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int IW = 1;

    logic             clk = 1'b0;
    logic             arst_n = 1'b0;
    logic             halt = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_wen = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*WW-1:0] req_data = '0;
    logic [NR-1:0]    req_ready, rsp_valid;
    logic [WW-1:0]    rsp_data, rf_data;
    logic             rsp_init, err, rf_valid, rf_wen, rf_halt;
    logic [AW-1:0]    rf_addr;
    logic [IW-1:0]    rf_tag;

    logic             rfo_valid, rfo_init;
    logic [WW-1:0]    rfo_data;
    logic [IW-1:0]    rfo_tag;
    logic             rf_bad = 1'b0;
    logic [WW-1:0]    rf_mem [8];
    logic             rf_minit [8];

    int n_chk = 0, n_err = 0, cyc = 0, n_strobe = 0;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
        int            id;
    } op_t;

    op_t           iss_q[$];
    op_t           cur;
    int            m_last = NR - 1;
    logic          m_due = 1'b0, m_rinit = 1'b0, m_err = 1'b0;
    logic [WW-1:0] m_rdata = '0;
    int            m_rid = 0;
    logic [WW-1:0] sh_mem [8];
    logic          sh_init [8];

    status_rf_arbiter dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_halt         (halt),
        .i_req_valid    (req_valid),
        .i_req_wen      (req_wen),
        .i_req_addr     (req_addr),
        .i_req_data     (req_data),
        .o_req_ready    (req_ready),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_data     (rsp_data),
        .o_rsp_init     (rsp_init),
        .o_err          (err),
        .o_rf_valid     (rf_valid),
        .o_rf_wen       (rf_wen),
        .o_rf_addr      (rf_addr),
        .o_rf_data      (rf_data),
        .o_rf_tag       (rf_tag),
        .o_rf_halt      (rf_halt),
        .i_rf_valid     (rfo_valid),
        .i_rf_data_init (rfo_init),
        .i_rf_data      (rfo_data),
        .i_rf_tag       (rfo_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: one-cycle read latency, output held while idle, halted or writing.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rfo_valid <= 1'b0;
            rfo_init  <= 1'b0;
            rfo_data  <= '0;
            rfo_tag   <= '0;
            for (int i = 0; i < 8; i++) begin
                rf_mem[i]   <= '0;
                rf_minit[i] <= 1'b0;
            end
        end else if (rf_valid && !rf_halt) begin
            if (rf_wen) begin
                rf_mem[rf_addr]   <= rf_data;
                rf_minit[rf_addr] <= 1'b1;
            end else begin
                rfo_valid <= 1'b1;
                rfo_data  <= rf_mem[rf_addr];
                rfo_init  <= rf_minit[rf_addr];
                rfo_tag   <= rf_tag ^ rf_bad;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] s;
`ifdef STATUS_RF_ARB_RR_EN
        for (int o = 1; o <= NR; o++) begin
            s = v >> ((last + o) % NR);
            if (s[0]) return (last + o) % NR;
        end
`else
        for (int k = 0; k < NR; k++) begin
            s = v >> k;
            if (s[0] && last >= -1) return k;
        end
`endif
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        int            w;
        logic [NR-1:0] er, sh;
        if (!arst_n) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rf_valid", rf_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_init", rsp_init, 0);
            iss_q.delete();
            m_last = NR - 1;
            m_due  = 1'b0;
            m_err  = 1'b0;
            for (int i = 0; i < 8; i++) begin
                sh_mem[i]  = '0;
                sh_init[i] = 1'b0;
            end
        end else begin
            w  = halt ? -1 : pick(req_valid, m_last);
            er = (w < 0) ? '0 : (NR'(1) << w);
            chk("ready", req_ready, er);
            chk("rf_halt", rf_halt, halt);
            chk("rf_valid", rf_valid, iss_q.size() != 0);
            if (iss_q.size() != 0) begin
                chk("rf_wen", rf_wen, iss_q[0].wen);
                chk("rf_addr", rf_addr, iss_q[0].addr);
                chk("rf_data", rf_data, iss_q[0].data);
                chk("rf_tag", rf_tag, iss_q[0].id);
            end
            chk("rsp_valid", rsp_valid, m_due ? (NR'(1) << m_rid) : '0);
            if (m_due) begin
                chk("rsp_data", rsp_data, m_rdata);
                chk("rsp_init", rsp_init, m_rinit);
            end else begin
                chk("rsp_data_pass", rsp_data, rfo_data);
            end
            chk("err", err, m_err);
            if (|rsp_valid) n_strobe++;
            if (m_due && (!rfo_valid || rfo_tag != IW'(m_rid))) m_err = 1'b1;
            m_due = 1'b0;
            if (iss_q.size() != 0 && !halt) begin
                cur = iss_q.pop_front();
                if (cur.wen) begin
                    sh_mem[cur.addr]  = cur.data;
                    sh_init[cur.addr] = 1'b1;
                end else begin
                    m_due   = 1'b1;
                    m_rid   = cur.id;
                    m_rdata = sh_mem[cur.addr];
                    m_rinit = sh_init[cur.addr];
                end
            end
            if (w >= 0) begin
                sh       = req_wen >> w;
                cur.wen  = sh[0];
                cur.addr = AW'(req_addr >> (w * AW));
                cur.data = WW'(req_data >> (w * WW));
                cur.id   = w;
                iss_q.push_back(cur);
                m_last = w;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    task automatic issue(input int k, input logic wen, input logic [AW-1:0] ad,
                         input logic [WW-1:0] dt, output int ac);
        ac = -1;
        req_valid[k] = 1'b1;
        req_wen[k] = wen;
        req_addr[k*AW +: AW] = ad;
        req_data[k*WW +: WW] = dt;
        for (int i = 0; i < 20 && ac < 0; i++) begin
            @(negedge clk);
            if (req_ready[k]) ac = cyc;
            tick();
        end
        req_valid[k] = 1'b0;
        chk("accept_seen", ac >= 0, 1);
    endtask

    task automatic wait_rsp(output int rc, output logic [NR-1:0] v, output logic [WW-1:0] d,
                            output logic in);
        rc = -1;
        v = '0;
        d = '0;
        in = 1'b0;
        for (int i = 0; i < 12 && rc < 0; i++) begin
            @(negedge clk);
            if (|rsp_valid) begin
                rc = cyc;
                v = rsp_valid;
                d = rsp_data;
                in = rsp_init;
            end
        end
        chk("rsp_seen", rc >= 0, 1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            a, rc, s0;
        logic [NR-1:0] v;
        logic [WW-1:0] d;
        logic          in;
        logic [NR-1:0] g [6];

        apply_reset();
        issue(0, 1'b1, 3'd3, 12'hABC, a);
        issue(1, 1'b0, 3'd3, 12'h000, a);
        s0 = n_strobe;
        wait_rsp(rc, v, d, in);
        chk("t1_latency", rc - a, 2);
        chk("t1_strobe", v, 2'b10);
        chk("t1_data", d, 12'hABC);
        chk("t1_init", in, 1);
        repeat (5) begin
            @(negedge clk);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_rf_held", rfo_valid, 1);
        end
        tick();
        chk("t1_one_strobe", n_strobe - s0, 1);

        apply_reset();
        issue(0, 1'b0, 3'd5, 12'h000, a);
        s0 = n_strobe;
        wait_rsp(rc, v, d, in);
        chk("t2_latency", rc - a, 2);
        chk("t2_strobe", v, 2'b01);
        chk("t2_data", d, 12'h000);
        chk("t2_init", in, 0);
        repeat (4) tick();
        chk("t2_one_strobe", n_strobe - s0, 1);

        apply_reset();
        req_wen = '0;
        req_addr = {3'd2, 3'd1};
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            g[i] = req_ready;
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
`ifdef STATUS_RF_ARB_RR_EN
            chk("t3_grant", g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
            chk("t3_grant", g[i], 2'b01);
`endif
        end
        repeat (4) tick();

        apply_reset();
        issue(0, 1'b1, 3'd6, 12'h5A5, a);
        issue(1, 1'b0, 3'd6, 12'h000, a);
        s0 = n_strobe;
        halt = 1'b1;
        req_valid[0] = 1'b1;
        req_wen[0] = 1'b1;
        req_addr[2:0] = 3'd6;
        req_data[11:0] = 12'h111;
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_ready", req_ready, 0);
            chk("t4_rf_valid", rf_valid, 1);
            chk("t4_rf_wen", rf_wen, 0);
            chk("t4_rf_addr", rf_addr, 6);
            chk("t4_rf_tag", rf_tag, 1);
            tick();
        end
        halt = 1'b0;
        @(negedge clk);
        chk("t4_ready_after", req_ready, 2'b01);
        tick();
        req_valid[0] = 1'b0;
        wait_rsp(rc, v, d, in);
        chk("t4_latency", rc - a, 5);
        chk("t4_strobe", v, 2'b10);
        chk("t4_data", d, 12'h5A5);
        repeat (3) tick();
        chk("t4_one_strobe", n_strobe - s0, 1);

        issue(0, 1'b0, 3'd4, 12'h000, a);
        arst_n = 1'b0;
        s0 = n_strobe;
        @(negedge clk);
        chk("t6_rf_valid", rf_valid, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_ready", req_ready, 0);
        chk("t6_err", err, 0);
        tick();
        tick();
        arst_n = 1'b1;
        repeat (4) tick();
        chk("t6_no_strobe", n_strobe - s0, 0);

        rf_bad = 1'b1;
        issue(1, 1'b0, 3'd2, 12'h000, a);
        wait_rsp(rc, v, d, in);
        chk("t7_strobe", v, 2'b10);
        @(negedge clk);
        chk("t7_err_set", err, 1);
        rf_bad = 1'b0;
        tick();
        repeat (3) tick();
        @(negedge clk);
        chk("t7_err_sticky", err, 1);
        tick();
        apply_reset();
        @(negedge clk);
        chk("t7_err_cleared", err, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
